axis_checker_lite_mc: RTL and testbench

Multi-channel AXI4-Lite control/status block for N_CHANNELS AXI-Stream data checkers. It is the successor of the single-channel checker register front end: channel count, address width and defaults are parametrised, and AW and W are accepted independently. It adds WSTRB byte enables, SLVERR decoding, atomic status snapshots, sticky W1C error flags and a masked interrupt. Checker datapaths are external; this block drives their config buses and samples their status buses.

---
 rtl/axis_checker_lite_pkg.sv | 75 +++++++
 rtl/axis_checker_lite_chan_regs.sv | 111 +++++++++++
 rtl/axis_checker_lite_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_axis_checker_lite_mc.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_checker_lite_pkg.sv
// Shared constants, register map and types for the multi-channel AXI-Stream
// checker control/status block.
package axis_checker_lite_pkg;

    localparam logic [31:0] VERSION     = 32'h0002_0000;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Global page word offsets (addr[5:2])
    localparam logic [3:0] G_VERSION    = 4'h0;
    localparam logic [3:0] G_N_CHANNELS = 4'h1;
    localparam logic [3:0] G_FREQ_HZ    = 4'h2;
    localparam logic [3:0] G_N_BYTES    = 4'h3;
    localparam logic [3:0] G_IRQ_MASK   = 4'h4;
    localparam logic [3:0] G_IRQ_STATUS = 4'h5;

    // Channel page word offsets (addr[5:2])
    localparam logic [3:0] OFF_CTRL            = 4'h0;
    localparam logic [3:0] OFF_PACKET_SIZE     = 4'h1;
    localparam logic [3:0] OFF_READY_LIMIT     = 4'h2;
    localparam logic [3:0] OFF_NOT_READY_LIMIT = 4'h3;
    localparam logic [3:0] OFF_PORTION_SIZE    = 4'h4;
    localparam logic [3:0] OFF_DATA_ERROR      = 4'h5;
    localparam logic [3:0] OFF_PACKET_ERROR    = 4'h6;
    localparam logic [3:0] OFF_DATA_SPEED      = 4'h7;
    localparam logic [3:0] OFF_PACKET_SPEED    = 4'h8;
    localparam logic [3:0] OFF_STICKY          = 4'h9;

    localparam int unsigned CTRL_RESET        = 0;
    localparam int unsigned CTRL_ENABLE       = 1;
    localparam int unsigned CTRL_IGN_DATA     = 2;
    localparam int unsigned CTRL_IGN_PACKET   = 3;
    localparam int unsigned CTRL_MODE_RST_CNT = 4;

    localparam int unsigned STICKY_DATA   = 0;
    localparam int unsigned STICKY_PACKET = 1;

    typedef struct packed {
        logic        rst;
        logic        enable;
        logic        ign_data_err;
        logic        ign_packet_err;
        logic        mode_rst_counter;
        logic [31:0] packet_size;
        logic [31:0] ready_limit;
        logic [31:0] not_ready_limit;
        logic [31:0] portion_size;
    } chan_cfg_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PEND,
        R_VALID
    } rd_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic chan_rd_ok(input logic [3:0] off);
        return off <= OFF_STICKY;
    endfunction

    function automatic logic chan_wr_ok(input logic [3:0] off);
        return (off <= OFF_PORTION_SIZE) || (off == OFF_STICKY);
    endfunction

endpackage

// File: rtl/axis_checker_lite_chan_regs.sv
// One checker channel register bank: CTRL/config words, status snapshot
// and W1C sticky error flags, with local write decode and read mux.
module axis_checker_lite_chan_regs
    import axis_checker_lite_pkg::*;
#(
    parameter int unsigned DEFAULT_PACKET_SIZE  = 4096,
    parameter int unsigned DEFAULT_READY_LIMIT  = 4096,
    parameter int unsigned DEFAULT_BUSY_LIMIT   = 0,
    parameter int unsigned DEFAULT_PORTION_SIZE = 1048576
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        wr_en,
    input  logic [3:0]  wr_off,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        rd_en,
    input  logic [3:0]  rd_off,
    output logic [31:0] rd_data,
    input  logic [31:0] st_data_error,
    input  logic [31:0] st_packet_error,
    input  logic [31:0] st_data_speed,
    input  logic [31:0] st_packet_speed,
    input  logic        st_has_data_error,
    input  logic        st_has_packet_error,
    output chan_cfg_t   cfg,
    output logic [1:0]  sticky
);

    logic [4:0]  ctrl;
    logic [31:0] packet_size;
    logic [31:0] ready_limit;
    logic [31:0] not_ready_limit;
    logic [31:0] portion_size;
    logic [31:0] snap_packet_error;
    logic [31:0] snap_data_speed;
    logic [31:0] snap_packet_speed;
    logic [1:0]  sticky_set;
    logic [1:0]  sticky_clr;

    always_comb begin
        sticky_set              = '0;
        sticky_set[STICKY_DATA]   = st_has_data_error;
        sticky_set[STICKY_PACKET] = st_has_packet_error;
        sticky_clr = '0;
        if (wr_en && (wr_off == OFF_STICKY) && wr_strb[0]) sticky_clr = wr_data[1:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl              <= 5'b00001;
            packet_size       <= DEFAULT_PACKET_SIZE;
            ready_limit       <= DEFAULT_READY_LIMIT;
            not_ready_limit   <= DEFAULT_BUSY_LIMIT;
            portion_size      <= DEFAULT_PORTION_SIZE;
            snap_packet_error <= '0;
            snap_data_speed   <= '0;
            snap_packet_speed <= '0;
            sticky            <= '0;
        end else begin
            if (wr_en) begin
                case (wr_off)
                    OFF_CTRL:            ctrl <= 5'(apply_wstrb({27'b0, ctrl}, wr_data, wr_strb));
                    OFF_PACKET_SIZE:     packet_size     <= apply_wstrb(packet_size, wr_data, wr_strb);
                    OFF_READY_LIMIT:     ready_limit     <= apply_wstrb(ready_limit, wr_data, wr_strb);
                    OFF_NOT_READY_LIMIT: not_ready_limit <= apply_wstrb(not_ready_limit, wr_data, wr_strb);
                    OFF_PORTION_SIZE:    portion_size    <= apply_wstrb(portion_size, wr_data, wr_strb);
                    default: ;
                endcase
            end
            // Reading DATA_ERROR freezes the other three counters for coherent readout
            if (rd_en && (rd_off == OFF_DATA_ERROR)) begin
                snap_packet_error <= st_packet_error;
                snap_data_speed   <= st_data_speed;
                snap_packet_speed <= st_packet_speed;
            end
            sticky <= (sticky & ~sticky_clr) | sticky_set;
        end
    end

    always_comb begin
        cfg                  = '0;
        cfg.rst              = ctrl[CTRL_RESET];
        cfg.enable           = ctrl[CTRL_ENABLE];
        cfg.ign_data_err     = ctrl[CTRL_IGN_DATA];
        cfg.ign_packet_err   = ctrl[CTRL_IGN_PACKET];
        cfg.mode_rst_counter = ctrl[CTRL_MODE_RST_CNT];
        cfg.packet_size      = packet_size;
        cfg.ready_limit      = ready_limit;
        cfg.not_ready_limit  = not_ready_limit;
        cfg.portion_size     = portion_size;
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_CTRL:            rd_data = {27'b0, ctrl};
            OFF_PACKET_SIZE:     rd_data = packet_size;
            OFF_READY_LIMIT:     rd_data = ready_limit;
            OFF_NOT_READY_LIMIT: rd_data = not_ready_limit;
            OFF_PORTION_SIZE:    rd_data = portion_size;
            OFF_DATA_ERROR:      rd_data = st_data_error;
            OFF_PACKET_ERROR:    rd_data = snap_packet_error;
            OFF_DATA_SPEED:      rd_data = snap_data_speed;
            OFF_PACKET_SPEED:    rd_data = snap_packet_speed;
            OFF_STICKY:          rd_data = {30'b0, sticky};
            default: ;
        endcase
    end

endmodule

// File: rtl/axis_checker_lite_mc.sv
// AXI4-Lite front end for N_CHANNELS AXI-Stream checkers: independent AW/W
// buffering, SLVERR decode, per-channel register banks and masked IRQ.
module axis_checker_lite_mc
    import axis_checker_lite_pkg::*;
#(
    parameter int unsigned N_CHANNELS           = 4,
    parameter int unsigned ADDR_WIDTH           = 10,
    parameter int unsigned FREQ_HZ              = 250000000,
    parameter int unsigned N_BYTES              = 4,
    parameter int unsigned DEFAULT_PACKET_SIZE  = 4096,
    parameter int unsigned DEFAULT_READY_LIMIT  = 4096,
    parameter int unsigned DEFAULT_BUSY_LIMIT   = 0,
    parameter int unsigned DEFAULT_PORTION_SIZE = 1048576
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [31:0]                wdata,
    input  logic [3:0]                 wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [31:0]                rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [N_CHANNELS-1:0]      CFG_RESET,
    output logic [N_CHANNELS-1:0]      CFG_ENABLE,
    output logic [N_CHANNELS-1:0]      CFG_IGNORE_DATA_ERROR,
    output logic [N_CHANNELS-1:0]      CFG_IGNORE_PACKET_ERROR,
    output logic [N_CHANNELS-1:0]      CFG_MODE_RST_COUNTER,
    output logic [32*N_CHANNELS-1:0]   CFG_PACKET_SIZE,
    output logic [32*N_CHANNELS-1:0]   CFG_READY_LIMIT,
    output logic [32*N_CHANNELS-1:0]   CFG_NOT_READY_LIMIT,
    output logic [32*N_CHANNELS-1:0]   CFG_PORTION_SIZE,
    input  logic [32*N_CHANNELS-1:0]   ST_DATA_ERROR,
    input  logic [32*N_CHANNELS-1:0]   ST_PACKET_ERROR,
    input  logic [32*N_CHANNELS-1:0]   ST_DATA_SPEED,
    input  logic [32*N_CHANNELS-1:0]   ST_PACKET_SPEED,
    input  logic [N_CHANNELS-1:0]      ST_HAS_DATA_ERROR,
    input  logic [N_CHANNELS-1:0]      ST_HAS_PACKET_ERROR,
    output logic                       IRQ
);

    localparam int unsigned PW = ADDR_WIDTH - 6;

    logic                  init_done;
    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:2] aw_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [N_CHANNELS-1:0] irq_mask;
    logic [N_CHANNELS-1:0] irq_status;
    logic [N_CHANNELS-1:0] chan_wr_en;
    logic [N_CHANNELS-1:0] chan_rd_en;
    logic [31:0]           chan_rdata [N_CHANNELS];
    logic [1:0]            chan_sticky [N_CHANNELS];
    logic                  commit;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [31:0]           rd_val;
    logic                  ar_hs;
    rd_state_t             rd_state;
    rd_state_t             rd_next;

    logic [PW-1:0] wr_page;
    logic [3:0]    wr_off;
    logic [PW-1:0] rd_page;
    logic [3:0]    rd_off;

    logic unused_bits;
    assign unused_bits = &{1'b0, awprot, arprot, awaddr[1:0], araddr[1:0]};

    assign wr_page = aw_addr[ADDR_WIDTH-1:6];
    assign wr_off  = aw_addr[5:2];
    assign rd_page = araddr[ADDR_WIDTH-1:6];
    assign rd_off  = araddr[5:2];

    assign awready = init_done && !aw_full;
    assign wready  = init_done && !w_full;
    assign commit  = aw_full && w_full && !bvalid;
    assign arready = init_done && (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_VALID);
    assign ar_hs   = arvalid && arready;

    always_comb begin
        wr_ok = 1'b0;
        if (wr_page == '0)                        wr_ok = (wr_off == G_IRQ_MASK);
        else if (wr_page <= PW'(N_CHANNELS))      wr_ok = chan_wr_ok(wr_off);
    end

    always_comb begin
        rd_ok  = 1'b0;
        rd_val = '0;
        if (rd_page == '0) begin
            rd_ok = 1'b1;
            case (rd_off)
                G_VERSION:    rd_val = VERSION;
                G_N_CHANNELS: rd_val = 32'(N_CHANNELS);
                G_FREQ_HZ:    rd_val = 32'(FREQ_HZ);
                G_N_BYTES:    rd_val = 32'(N_BYTES);
                G_IRQ_MASK:   rd_val = 32'(irq_mask);
                G_IRQ_STATUS: rd_val = 32'(irq_status);
                default:      rd_ok  = 1'b0;
            endcase
        end else begin
            for (int unsigned c = 0; c < N_CHANNELS; c++) begin
                if ((rd_page == PW'(c + 1)) && chan_rd_ok(rd_off)) begin
                    rd_ok  = 1'b1;
                    rd_val = chan_rdata[c];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_done <= 1'b0;
            aw_full   <= 1'b0;
            aw_addr   <= '0;
            w_full    <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            bvalid    <= 1'b0;
            bresp     <= '0;
            irq_mask  <= '0;
            IRQ       <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok && (wr_page == '0))
                    irq_mask <= N_CHANNELS'(apply_wstrb(32'(irq_mask), w_data, w_strb));
            end
            IRQ <= |(irq_status & irq_mask);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            rdata    <= '0;
            rresp    <= '0;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rdata <= rd_ok ? rd_val : '0;
                rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_PEND;
            R_PEND:  rd_next = R_VALID;
            R_VALID: if (rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
        chan_cfg_t cfg;

        assign chan_wr_en[c] = commit && wr_ok && (wr_page == PW'(c + 1));
        assign chan_rd_en[c] = ar_hs && (rd_page == PW'(c + 1));

        axis_checker_lite_chan_regs #(
            .DEFAULT_PACKET_SIZE  (DEFAULT_PACKET_SIZE),
            .DEFAULT_READY_LIMIT  (DEFAULT_READY_LIMIT),
            .DEFAULT_BUSY_LIMIT   (DEFAULT_BUSY_LIMIT),
            .DEFAULT_PORTION_SIZE (DEFAULT_PORTION_SIZE)
        ) u_regs (
            .aclk                (aclk),
            .aresetn             (aresetn),
            .wr_en               (chan_wr_en[c]),
            .wr_off              (wr_off),
            .wr_data             (w_data),
            .wr_strb             (w_strb),
            .rd_en               (chan_rd_en[c]),
            .rd_off              (rd_off),
            .rd_data             (chan_rdata[c]),
            .st_data_error       (ST_DATA_ERROR[32*c +: 32]),
            .st_packet_error     (ST_PACKET_ERROR[32*c +: 32]),
            .st_data_speed       (ST_DATA_SPEED[32*c +: 32]),
            .st_packet_speed     (ST_PACKET_SPEED[32*c +: 32]),
            .st_has_data_error   (ST_HAS_DATA_ERROR[c]),
            .st_has_packet_error (ST_HAS_PACKET_ERROR[c]),
            .cfg                 (cfg),
            .sticky              (chan_sticky[c])
        );

        assign CFG_RESET[c]                   = cfg.rst;
        assign CFG_ENABLE[c]                  = cfg.enable;
        assign CFG_IGNORE_DATA_ERROR[c]       = cfg.ign_data_err;
        assign CFG_IGNORE_PACKET_ERROR[c]     = cfg.ign_packet_err;
        assign CFG_MODE_RST_COUNTER[c]        = cfg.mode_rst_counter;
        assign CFG_PACKET_SIZE[32*c +: 32]     = cfg.packet_size;
        assign CFG_READY_LIMIT[32*c +: 32]     = cfg.ready_limit;
        assign CFG_NOT_READY_LIMIT[32*c +: 32] = cfg.not_ready_limit;
        assign CFG_PORTION_SIZE[32*c +: 32]    = cfg.portion_size;
        assign irq_status[c]                  = |chan_sticky[c];
    end

endmodule

// File: tb/tb_axis_checker_lite_mc.sv
// Directed bench for axis_checker_lite_mc: register-map vector table plus
// hand-written handshake, snapshot, sticky/IRQ and reset sequences.
module tb_axis_checker_lite_mc;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [9:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [9:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [3:0]   CFG_RESET, CFG_ENABLE, CFG_IGNORE_DATA_ERROR, CFG_IGNORE_PACKET_ERROR, CFG_MODE_RST_COUNTER;
    logic [127:0] CFG_PACKET_SIZE, CFG_READY_LIMIT, CFG_NOT_READY_LIMIT, CFG_PORTION_SIZE;
    logic [127:0] ST_DATA_ERROR, ST_PACKET_ERROR, ST_DATA_SPEED, ST_PACKET_SPEED;
    logic [3:0]   ST_HAS_DATA_ERROR, ST_HAS_PACKET_ERROR;
    logic         IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_checker_lite_mc #(
        .N_CHANNELS (4),
        .ADDR_WIDTH (10)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .CFG_RESET(CFG_RESET), .CFG_ENABLE(CFG_ENABLE),
        .CFG_IGNORE_DATA_ERROR(CFG_IGNORE_DATA_ERROR),
        .CFG_IGNORE_PACKET_ERROR(CFG_IGNORE_PACKET_ERROR),
        .CFG_MODE_RST_COUNTER(CFG_MODE_RST_COUNTER),
        .CFG_PACKET_SIZE(CFG_PACKET_SIZE), .CFG_READY_LIMIT(CFG_READY_LIMIT),
        .CFG_NOT_READY_LIMIT(CFG_NOT_READY_LIMIT), .CFG_PORTION_SIZE(CFG_PORTION_SIZE),
        .ST_DATA_ERROR(ST_DATA_ERROR), .ST_PACKET_ERROR(ST_PACKET_ERROR),
        .ST_DATA_SPEED(ST_DATA_SPEED), .ST_PACKET_SPEED(ST_PACKET_SPEED),
        .ST_HAS_DATA_ERROR(ST_HAS_DATA_ERROR), .ST_HAS_PACKET_ERROR(ST_HAS_PACKET_ERROR),
        .IRQ(IRQ)
    );

    typedef struct {
        logic        is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic is_wr, input logic [9:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_data = exp_data; v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) timeout_fail("aw_w_accept");
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) timeout_fail("bvalid_wait");
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [9:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        logic hs;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            hs = arready;
            tick();
            n++;
        end
        if (!hs) timeout_fail("ar_accept");
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) timeout_fail("rvalid_wait");
        data = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        vecs[0]  = mk(0, 10'h044, 0, 0, 32'd4096, 2'b00);        // page1 PACKET_SIZE default
        vecs[1]  = mk(0, 10'h040, 0, 0, 32'h1, 2'b00);           // page1 CTRL reset value
        vecs[2]  = mk(0, 10'h004, 0, 0, 32'd4, 2'b00);           // N_CHANNELS
        vecs[3]  = mk(0, 10'h000, 0, 0, 32'h0002_0000, 2'b00);   // VERSION
        vecs[4]  = mk(0, 10'h008, 0, 0, 32'd250000000, 2'b00);   // FREQ_HZ
        vecs[5]  = mk(0, 10'h00C, 0, 0, 32'd4, 2'b00);           // N_BYTES
        vecs[6]  = mk(1, 10'h048, 32'hAABB_CCDD, 4'b0101, 0, 2'b00);
        vecs[7]  = mk(0, 10'h048, 0, 0, 32'h00BB_10DD, 2'b00);   // partial-strobe merge
        vecs[8]  = mk(0, 10'h140, 0, 0, 32'h0, 2'b10);           // page 5 unmapped
        vecs[9]  = mk(0, 10'h03C, 0, 0, 32'h0, 2'b10);           // global 0x3C unmapped
        vecs[10] = mk(1, 10'h000, 32'h1234_5678, 4'hF, 0, 2'b10); // write RO VERSION
        vecs[11] = mk(0, 10'h000, 0, 0, 32'h0002_0000, 2'b00);
        vecs[12] = mk(1, 10'h054, 32'h1, 4'hF, 0, 2'b10);        // write RO DATA_ERROR
        vecs[13] = mk(0, 10'h068, 0, 0, 32'h0, 2'b10);           // channel offset 0x28
        vecs[14] = mk(1, 10'h0D0, 32'h1122_3344, 4'hF, 0, 2'b00); // page3 PORTION_SIZE
        vecs[15] = mk(0, 10'h0D0, 0, 0, 32'h1122_3344, 2'b00);
        vecs[16] = mk(0, 10'h0CC, 0, 0, 32'h0, 2'b00);           // NOT_READY_LIMIT default
        vecs[17] = mk(0, 10'h108, 0, 0, 32'd4096, 2'b00);        // page4 READY_LIMIT
        vecs[18] = mk(0, 10'h010, 0, 0, 32'h0, 2'b00);           // IRQ_MASK reset
        vecs[19] = mk(0, 10'h047, 0, 0, 32'd4096, 2'b00);        // addr[1:0] ignored

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        ST_DATA_ERROR = '0; ST_PACKET_ERROR = '0; ST_DATA_SPEED = '0; ST_PACKET_SPEED = '0;
        ST_HAS_DATA_ERROR = '0; ST_HAS_PACKET_ERROR = '0;

        repeat (3) tick();
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", 32'(IRQ), 0);
        check("rst_cfg_reset", 32'(CFG_RESET), 32'hF);
        check("rst_cfg_psize0", CFG_PACKET_SIZE[31:0], 32'd4096);
        aresetn = 1'b1;
        check("rel_awready_low", 32'(awready), 0);
        tick();
        check("rel_awready", 32'(awready), 1);
        check("rel_wready", 32'(wready), 1);
        check("rel_arready", 32'(arready), 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            end
            check($sformatf("vec%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
        end
        check("cfg_ready_limit0", CFG_READY_LIMIT[31:0], 32'h00BB_10DD);
        check("cfg_portion2", CFG_PORTION_SIZE[95:64], 32'h1122_3344);

        // W presented three cycles ahead of AW
        wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        check("wfirst_wready", 32'(wready), 1);
        tick();
        wvalid = 1'b0;
        tick(); tick();
        check("wfirst_wready_full", 32'(wready), 0);
        check("wfirst_no_b", 32'(bvalid), 0);
        awaddr = 10'h080; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_b_not_yet", 32'(bvalid), 0);
        check("wfirst_enable_old", 32'(CFG_ENABLE[1]), 0);
        tick();
        check("wfirst_bvalid", 32'(bvalid), 1);
        check("wfirst_bresp", 32'(bresp), 0);
        check("wfirst_enable", 32'(CFG_ENABLE[1]), 1);
        check("wfirst_reset", 32'(CFG_RESET[1]), 0);
        check("wfirst_freed", 32'({awready, wready}), 32'h3);
        bready = 1'b1; tick(); bready = 1'b0;

        // Snapshot coherence
        ST_DATA_ERROR[31:0] = 32'd7; ST_PACKET_ERROR[31:0] = 32'd55; ST_PACKET_SPEED[31:0] = 32'd100;
        axi_read(10'h054, d, r);
        check("snap_live_derr", d, 32'd7);
        ST_DATA_ERROR[31:0] = 32'd9; ST_PACKET_SPEED[31:0] = 32'd200; ST_PACKET_ERROR[31:0] = 32'd66;
        axi_read(10'h060, d, r);
        check("snap_pspeed_held", d, 32'd100);
        axi_read(10'h058, d, r);
        check("snap_perr_held", d, 32'd55);
        axi_read(10'h054, d, r);
        check("snap_live_derr2", d, 32'd9);
        axi_read(10'h060, d, r);
        check("snap_pspeed_new", d, 32'd200);

        // Sticky / IRQ
        axi_write(10'h010, 32'h4, 4'hF, r);
        check("mask_resp", 32'(r), 0);
        check("irq_idle", 32'(IRQ), 0);
        ST_HAS_DATA_ERROR = 4'b0100;
        tick();
        ST_HAS_DATA_ERROR = 4'b0000;
        check("irq_latency", 32'(IRQ), 0);
        tick();
        check("irq_set", 32'(IRQ), 1);
        axi_read(10'h014, d, r);
        check("irq_status", d, 32'h4);
        axi_read(10'h0E4, d, r);
        check("sticky3", d, 32'h1);
        axi_write(10'h0E4, 32'h1, 4'b0000, r);
        axi_read(10'h0E4, d, r);
        check("sticky_nostrb", d, 32'h1);
        awaddr = 10'h0E4; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("irq_after_commit", 32'(IRQ), 1);
        tick();
        check("irq_cleared", 32'(IRQ), 0);
        bready = 1'b1; tick(); bready = 1'b0;
        ST_HAS_DATA_ERROR = 4'b0100;
        tick();
        ST_HAS_DATA_ERROR = 4'b0000;
        tick();
        check("irq_reset2", 32'(IRQ), 1);
        awaddr = 10'h0E4; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        ST_HAS_DATA_ERROR = 4'b0100;
        tick();
        ST_HAS_DATA_ERROR = 4'b0000;
        tick();
        check("irq_set_wins", 32'(IRQ), 1);
        bready = 1'b1; tick(); bready = 1'b0;
        check("irq_set_wins2", 32'(IRQ), 1);
        ST_HAS_PACKET_ERROR = 4'b0001;
        tick();
        ST_HAS_PACKET_ERROR = 4'b0000;
        axi_read(10'h064, d, r);
        check("sticky_pkt0", d, 32'h2);

        // B stall with a second write buffered behind it
        awaddr = 10'h000; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("stall_bvalid", 32'(bvalid), 1);
        check("stall_bresp", 32'(bresp), 2);
        check("stall_awready", 32'(awready), 1);
        awaddr = 10'h010; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_bvalid_%0d", i), 32'(bvalid), 1);
            check($sformatf("hold_bresp_%0d", i), 32'(bresp), 2);
            tick();
        end
        check("hold_aw_buffered", 32'(awready), 0);
        bready = 1'b1; tick(); bready = 1'b0;
        check("hold_b_done", 32'(bvalid), 0);
        tick();
        check("queued_bvalid", 32'(bvalid), 1);
        check("queued_bresp", 32'(bresp), 0);
        bready = 1'b1; tick(); bready = 1'b0;
        axi_read(10'h000, d, r);
        check("ro_unchanged", d, 32'h0002_0000);
        axi_read(10'h010, d, r);
        check("mask_cleared", d, 32'h0);

        // Reset in the middle of a write
        awaddr = 10'h080; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_aw_held", 32'(awready), 0);
        aresetn = 1'b0;
        #1;
        check("mid_rst_awready", 32'(awready), 0);
        check("mid_rst_cfg_reset", 32'(CFG_RESET), 32'hF);
        check("mid_rst_enable", 32'(CFG_ENABLE), 0);
        tick();
        aresetn = 1'b1;
        tick();
        check("mid_rel_awready", 32'(awready), 1);
        wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (3) tick();
        check("mid_no_response", 32'(bvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
